// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI3 slave backed by a word-addressed 32-bit memory
//
// Purpose: responder endpoint for AW/W/B/AR/R. Independent write and read
// state machines, one outstanding transaction each, FIXED/INCR/WRAP bursts
// of up to 16 beats with a fixed beat size of 4 bytes.
//
// Ports:
//   aclk, arst                       clock, synchronous active-low reset
//   aw* / awvalid / awready          write address channel
//   wid, wdata, wstrb, wlast, w*     write data channel
//   bid, bresp, bvalid, bready       write response channel
//   ar* / arvalid / arready          read address channel
//   rid, rdata, rresp, rlast, r*     read data channel
// All outputs are registered.

module axi_slave_mem #(
    parameter int DEPTH = 1024
) (
    input  logic        aclk,
    input  logic        arst,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [3:0]  awlen,
    input  logic [1:0]  awburst,
    input  logic [2:0]  awsize,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [3:0]  arlen,
    input  logic [1:0]  arburst,
    input  logic [2:0]  arsize,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    logic [31:0] mem [DEPTH];

    function automatic logic burst_illegal(input logic [3:0] len, input logic [1:0] burst,
                                           input logic [2:0] size);
        logic wrap_len_ok;
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        return (size != 3'b010) || (burst == 2'd3) || ((burst == 2'd2) && !wrap_len_ok);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                              input logic [1:0] burst);
        logic [31:0] mask;
        mask = ((32'(len) + 32'd1) << 2) - 32'd1;
        case (burst)
            2'd1:    return a + 32'd4;
            2'd2:    return (a & ~mask) | ((a + 32'd4) & mask);
            default: return a;
        endcase
    endfunction

    function automatic logic in_range(input logic [31:0] a);
        return a[31:2] < DEPTH_W;
    endfunction

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic [1:0]  w_state;
    logic [3:0]  aw_id_q;
    logic [31:0] aw_addr_q;
    logic [3:0]  aw_len_q;
    logic [1:0]  aw_burst_q;
    logic        aw_illegal_q;
    logic [3:0]  aw_cnt_q;
    logic        w_slverr_q;
    logic        w_decerr_q;

    logic        w_fire;
    logic        w_beat_last;
    logic        w_in_range;
    logic        w_beat_slverr;
    logic        w_beat_decerr;
    logic        mem_we;
    logic [1:0]  bresp_next;

    assign w_fire        = wvalid && wready;
    assign w_beat_last   = (aw_cnt_q == aw_len_q);
    assign w_in_range    = in_range(aw_addr_q);
    assign w_beat_slverr = (wlast != w_beat_last) || (wid != aw_id_q);
    assign w_beat_decerr = !aw_illegal_q && !w_in_range;
    // Gated by arst so the reset edge itself never commits a beat.
    assign mem_we        = arst && w_fire && !aw_illegal_q && w_in_range;

    // The final beat's own errors must be folded in, since the sticky
    // flags only update at the same edge that raises bvalid.
    always_comb begin
        bresp_next = RESP_OKAY;
        if (aw_illegal_q || w_slverr_q || w_beat_slverr) begin
            bresp_next = RESP_SLVERR;
        end else if (w_decerr_q || w_beat_decerr) begin
            bresp_next = RESP_DECERR;
        end
    end

    always_ff @(posedge aclk) begin
        if (!arst) begin
            w_state      <= W_IDLE;
            awready      <= 1'b0;
            wready       <= 1'b0;
            bvalid       <= 1'b0;
            bid          <= 4'd0;
            bresp        <= RESP_OKAY;
            aw_id_q      <= 4'd0;
            aw_addr_q    <= 32'd0;
            aw_len_q     <= 4'd0;
            aw_burst_q   <= 2'd0;
            aw_illegal_q <= 1'b0;
            aw_cnt_q     <= 4'd0;
            w_slverr_q   <= 1'b0;
            w_decerr_q   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        aw_id_q      <= awid;
                        aw_addr_q    <= awaddr;
                        aw_len_q     <= awlen;
                        aw_burst_q   <= awburst;
                        aw_illegal_q <= burst_illegal(awlen, awburst, awsize);
                        aw_cnt_q     <= 4'd0;
                        w_slverr_q   <= 1'b0;
                        w_decerr_q   <= 1'b0;
                        awready      <= 1'b0;
                        wready       <= 1'b1;
                        w_state      <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        aw_addr_q <= next_addr(aw_addr_q, aw_len_q, aw_burst_q);
                        aw_cnt_q  <= aw_cnt_q + 4'd1;
                        if (w_beat_slverr) w_slverr_q <= 1'b1;
                        if (w_beat_decerr) w_decerr_q <= 1'b1;
                        if (w_beat_last) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= aw_id_q;
                            bresp   <= bresp_next;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[aw_addr_q[IW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [31:0] r_addr_q;
    logic [3:0]  r_len_q;
    logic [1:0]  r_burst_q;
    logic        r_illegal_q;
    logic [3:0]  r_cnt_q;

    logic        ar_fire;
    logic        r_fire;
    logic [31:0] rd_addr;
    logic        rd_illegal;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    assign ar_fire = arvalid && arready;
    assign r_fire  = rvalid && rready;

    // In idle the beat being prepared is beat 0 of the incoming request;
    // afterwards it is the beat at the latched, already-advanced address.
    assign rd_addr    = (r_state == R_IDLE) ? araddr : r_addr_q;
    assign rd_illegal = (r_state == R_IDLE) ? burst_illegal(arlen, arburst, arsize) : r_illegal_q;

    always_comb begin
        rd_data = 32'd0;
        rd_resp = RESP_OKAY;
        if (rd_illegal) begin
            rd_resp = RESP_SLVERR;
        end else if (!in_range(rd_addr)) begin
            rd_resp = RESP_DECERR;
        end else begin
            rd_data = mem[rd_addr[IW+1:2]];
        end
    end

    always_ff @(posedge aclk) begin
        if (!arst) begin
            r_state     <= R_IDLE;
            arready     <= 1'b0;
            rvalid      <= 1'b0;
            rid         <= 4'd0;
            rdata       <= 32'd0;
            rresp       <= RESP_OKAY;
            rlast       <= 1'b0;
            r_addr_q    <= 32'd0;
            r_len_q     <= 4'd0;
            r_burst_q   <= 2'd0;
            r_illegal_q <= 1'b0;
            r_cnt_q     <= 4'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        rid         <= arid;
                        r_len_q     <= arlen;
                        r_burst_q   <= arburst;
                        r_illegal_q <= rd_illegal;
                        r_addr_q    <= next_addr(araddr, arlen, arburst);
                        r_cnt_q     <= 4'd0;
                        rdata       <= rd_data;
                        rresp       <= rd_resp;
                        rlast       <= (arlen == 4'd0);
                        rvalid      <= 1'b1;
                        arready     <= 1'b0;
                        r_state     <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            rdata   <= 32'd0;
                            rresp   <= RESP_OKAY;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            rdata    <= rd_data;
                            rresp    <= rd_resp;
                            rlast    <= ((r_cnt_q + 4'd1) == r_len_q);
                            r_cnt_q  <= r_cnt_q + 4'd1;
                            r_addr_q <= next_addr(r_addr_q, r_len_q, r_burst_q);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - self-checking bench for axi_slave_mem

module tb_axi_slave_mem;

    localparam int DEPTH = 1024;

    logic        aclk = 1'b0;
    logic        arst;
    logic [31:0] awaddr;
    logic [3:0]  awid, awlen;
    logic [1:0]  awburst;
    logic [2:0]  awsize;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] araddr;
    logic [3:0]  arid, arlen;
    logic [1:0]  arburst;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    always #5 aclk = ~aclk;

    axi_slave_mem #(.DEPTH(DEPTH)) dut (
        .aclk(aclk), .arst(arst),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awburst(awburst), .awsize(awsize),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arburst(arburst), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEPTH];
    logic [1:0]  exp_bresp_q[$];
    logic [3:0]  exp_bid_q[$];
    logic [31:0] exp_rdata_q[$];
    logic [1:0]  exp_rresp_q[$];
    logic        exp_rlast_q[$];
    logic [3:0]  exp_rid_q[$];
    logic [31:0] got_data [16];
    logic [1:0]  got_resp [16];
    logic [1:0]  last_bresp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic is_illegal(input logic [3:0] len, input logic [1:0] burst,
                                        input logic [2:0] size);
        return size != 3'd2 || burst == 2'd3 ||
               (burst == 2'd2 && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    endfunction

    function automatic logic [31:0] adv(input logic [31:0] a, input logic [3:0] len,
                                        input logic [1:0] burst);
        logic [31:0] mask;
        mask = (32'(len) + 1) * 4 - 1;
        if (burst == 2'd1) return a + 4;
        if (burst == 2'd2) return (a & ~mask) | ((a + 4) & mask);
        return a;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input logic [31:0] base,
                             input logic [3:0] strb, input int early_last, input bit bp);
        logic [31:0] a, d;
        logic        ill, slv, dec, lb, stalled, done;
        logic [3:0]  pb_bid;
        logic [1:0]  pb_bresp;
        int          n;
        a = addr; ill = is_illegal(len, burst, size); slv = ill; dec = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            lb = (early_last >= 0) ? (i == early_last) : (i == int'(len));
            if (lb != (i == int'(len))) slv = 1'b1;
            d = base + 32'(i);
            if (!ill) begin
                if (a[31:12] == 20'd0) begin
                    for (int b = 0; b < 4; b++) if (strb[b]) model[a[11:2]][8*b +: 8] = d[8*b +: 8];
                end else dec = 1'b1;
            end
            a = adv(a, len, burst);
        end
        exp_bresp_q.push_back(slv ? 2'd2 : (dec ? 2'd3 : 2'd0));
        exp_bid_q.push_back(id);

        @(negedge aclk);
        awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awburst = burst; awsize = size;
        n = 0;
        while (!awready && n < 200) begin @(negedge aclk); n++; end
        check("aw_timeout", 32'(n >= 200), 32'd0);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (bp) begin
                wvalid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge aclk);
            end
            wvalid = 1'b1; wid = id; wdata = base + 32'(i); wstrb = strb;
            wlast = (early_last >= 0) ? (i == early_last) : (i == int'(len));
            n = 0;
            while (!wready && n < 200) begin @(negedge aclk); n++; end
            check("w_timeout", 32'(n >= 200), 32'd0);
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;

        n = 0; done = 1'b0; stalled = 1'b0;
        while (!done && n < 200) begin
            bready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                check("b_hold_valid", 32'(bvalid), 32'd1);
                check("b_hold_bid", 32'(bid), 32'(pb_bid));
                check("b_hold_bresp", 32'(bresp), 32'(pb_bresp));
            end
            stalled = 1'b0;
            if (bvalid) begin
                if (bready) begin
                    check("bresp", 32'(bresp), 32'(exp_bresp_q.pop_front()));
                    check("bid", 32'(bid), 32'(exp_bid_q.pop_front()));
                    last_bresp = bresp;
                    done = 1'b1;
                end else begin
                    stalled = 1'b1; pb_bid = bid; pb_bresp = bresp;
                end
            end
            @(negedge aclk);
            n++;
        end
        bready = 1'b0;
        check("b_timeout", 32'(done), 32'd1);
        check("b_drop", 32'(bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input bit bp);
        logic [31:0] a, pd;
        logic [1:0]  pr;
        logic        ill, pl, stalled;
        int          n, beat;
        a = addr; ill = is_illegal(len, burst, size);
        for (int i = 0; i <= int'(len); i++) begin
            if (ill) begin
                exp_rdata_q.push_back(32'd0); exp_rresp_q.push_back(2'd2);
            end else if (a[31:12] != 20'd0) begin
                exp_rdata_q.push_back(32'd0); exp_rresp_q.push_back(2'd3);
            end else begin
                exp_rdata_q.push_back(model[a[11:2]]); exp_rresp_q.push_back(2'd0);
            end
            exp_rlast_q.push_back(i == int'(len));
            exp_rid_q.push_back(id);
            a = adv(a, len, burst);
        end

        @(negedge aclk);
        arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arburst = burst; arsize = size;
        n = 0;
        while (!arready && n < 200) begin @(negedge aclk); n++; end
        check("ar_timeout", 32'(n >= 200), 32'd0);
        @(negedge aclk);
        arvalid = 1'b0;

        n = 0; beat = 0; stalled = 1'b0;
        while (beat <= int'(len) && n < 400) begin
            rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                check("r_hold_valid", 32'(rvalid), 32'd1);
                check("r_hold_data", rdata, pd);
                check("r_hold_resp", 32'(rresp), 32'(pr));
                check("r_hold_last", 32'(rlast), 32'(pl));
            end
            stalled = 1'b0;
            if (rvalid) begin
                if (rready) begin
                    check("rdata", rdata, exp_rdata_q.pop_front());
                    check("rresp", 32'(rresp), 32'(exp_rresp_q.pop_front()));
                    check("rlast", 32'(rlast), 32'(exp_rlast_q.pop_front()));
                    check("rid", 32'(rid), 32'(exp_rid_q.pop_front()));
                    got_data[beat] = rdata;
                    got_resp[beat] = rresp;
                    beat++;
                end else begin
                    stalled = 1'b1; pd = rdata; pr = rresp; pl = rlast;
                end
            end
            @(negedge aclk);
            n++;
        end
        rready = 1'b0;
        check("r_timeout", 32'(beat), 32'(int'(len) + 1));
        check("r_no_extra", 32'(rvalid), 32'd0);
        check("arready_after", 32'(arready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b0;
        awaddr = '0; awid = '0; awlen = '0; awburst = '0; awsize = '0; awvalid = 1'b1;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arid = '0; arlen = '0; arburst = '0; arsize = '0; arvalid = 1'b0;
        rready = 1'b0;

        // Reset held for 3 edges with awvalid asserted
        repeat (3) @(negedge aclk);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        awvalid = 1'b0;
        arst = 1'b1;
        @(negedge aclk);
        check("rel_awready", 32'(awready), 32'd1);
        check("rel_arready", 32'(arready), 32'd1);

        // INCR write/read
        axi_write(32'h10, 4'd5, 4'd3, 2'd1, 3'd2, 32'hA0, 4'hF, -1, 1'b0);
        check("incr_bresp", 32'(last_bresp), 32'd0);
        axi_read(32'h10, 4'd6, 4'd3, 2'd1, 3'd2, 1'b0);
        for (int i = 0; i < 4; i++) check("incr_data", got_data[i], 32'hA0 + 32'(i));

        // Illegal size: SLVERR and no memory change
        axi_write(32'h10, 4'd7, 4'd3, 2'd1, 3'd1, 32'hEE, 4'hF, -1, 1'b0);
        check("illw_bresp", 32'(last_bresp), 32'd2);
        axi_read(32'h10, 4'd1, 4'd3, 2'd1, 3'd2, 1'b0);
        check("illw_keep", got_data[0], 32'hA0);

        // WRAP read order
        axi_write(32'h30, 4'd2, 4'd3, 2'd1, 3'd2, 32'hB0, 4'hF, -1, 1'b0);
        axi_read(32'h38, 4'd3, 4'd3, 2'd2, 3'd2, 1'b0);
        check("wrap_b0", got_data[0], 32'hB2);
        check("wrap_b1", got_data[1], 32'hB3);
        check("wrap_b2", got_data[2], 32'hB0);
        check("wrap_b3", got_data[3], 32'hB1);
        axi_read(32'h38, 4'd4, 4'd2, 2'd2, 3'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("wrap2_resp", 32'(got_resp[i]), 32'd2);
            check("wrap2_data", got_data[i], 32'd0);
        end

        // Partial strobe
        axi_write(32'h80, 4'd8, 4'd0, 2'd1, 3'd2, 32'h11223344, 4'hF, -1, 1'b0);
        axi_write(32'h80, 4'd8, 4'd0, 2'd1, 3'd2, 32'hAABBCCDD, 4'b0101, -1, 1'b0);
        axi_read(32'h80, 4'd9, 4'd0, 2'd1, 3'd2, 1'b0);
        check("strobe_merge", got_data[0], 32'h11BB33DD);

        // Out of range
        axi_write(32'hFF8, 4'd10, 4'd3, 2'd1, 3'd2, 32'hD0, 4'hF, -1, 1'b0);
        check("oor_bresp", 32'(last_bresp), 32'd3);
        axi_read(32'hFF8, 4'd11, 4'd3, 2'd1, 3'd2, 1'b0);
        check("oor_b0", got_data[0], 32'hD0);
        check("oor_b1", got_data[1], 32'hD1);
        check("oor_r2", 32'(got_resp[2]), 32'd3);
        check("oor_r3", 32'(got_resp[3]), 32'd3);
        check("oor_d3", got_data[3], 32'd0);

        // Concurrent read and write under random backpressure
        fork
            axi_write(32'h200, 4'd12, 4'd7, 2'd1, 3'd2, 32'hC0, 4'hF, -1, 1'b1);
            axi_read(32'h10, 4'd13, 4'd3, 2'd1, 3'd2, 1'b1);
        join
        fork
            axi_write(32'h240, 4'd14, 4'd3, 2'd0, 3'd2, 32'hE0, 4'hF, -1, 1'b1);
            axi_read(32'h200, 4'd15, 4'd7, 2'd1, 3'd2, 1'b1);
        join
        check("conc_last", got_data[7], 32'hC7);
        axi_read(32'h240, 4'd0, 4'd0, 2'd1, 3'd2, 1'b1);
        check("fixed_final", got_data[0], 32'hE3);

        // Premature wlast on beat 1 of a 4-beat burst
        axi_write(32'h300, 4'd3, 4'd3, 2'd1, 3'd2, 32'hF0, 4'hF, 1, 1'b0);
        check("early_last_bresp", 32'(last_bresp), 32'd2);
        axi_read(32'h300, 4'd3, 4'd3, 2'd1, 3'd2, 1'b0);
        check("early_last_data", got_data[3], 32'hF3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
